reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/mcu51_pkg.sv | 10 +
 rtl/rstpin_filter.sv | 20 ++
 rtl/reset_sequencer.sv | 78 +++++++
 tb/tb_reset_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcu51_pkg.sv
// mcu51_pkg: shared mcu51 encodings for reset sequencing and the RSTSRC register
package mcu51_pkg;
    typedef enum logic {ST_ASSERT = 1'b0, ST_RUN = 1'b1} rst_state_t;
    localparam int RS_POR = 0;
    localparam int RS_EXT = 1;
    localparam int RS_SOFT = 2;
    localparam int RS_WDT = 3;
    localparam logic [6:0] RSTSRC_ID_DEF = 7'h71;
    localparam logic [7:0] RSTSRC_RST = 8'h01;
endpackage

// File: rtl/rstpin_filter.sv
// rstpin_filter: synchronizes extrst_n and qualifies it after 3 consecutive low samples
module rstpin_filter (
    input  logic clkcpu,
    input  logic rstn,
    input  logic extrst_n,
    output logic ext_req
);
    logic [1:0] sync_low;
    logic [2:0] hist;
    always_ff @(posedge clkcpu or negedge rstn) begin
        if (!rstn) begin
            sync_low <= '0;
            hist <= '0;
        end else begin
            sync_low <= {sync_low[0], ~extrst_n};
            hist <= {hist[1:0], sync_low[1]};
        end
    end
    assign ext_req = &hist;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: stretches POR/external/software/watchdog resets into resetff and records the cause in RSTSRC
// Define WDT_RESET_EN to let wdtreq trigger resets and set RSTSRC[3].
module reset_sequencer
    import mcu51_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter logic [6:0] RSTSRC_ID = RSTSRC_ID_DEF
) (
    input  logic       clkcpu,
    input  logic       rstn,
    input  logic       extrst_n,
    input  logic       srstreq,
    input  logic       wdtreq,
    input  logic [6:0] sfraddr,
    input  logic [7:0] sfrdatai,
    input  logic       sfrwe,
    output logic [7:0] sfrdatao,
    output logic       resetff
);
    localparam logic [4:0] LAST = 5'(RST_CYCLES - 1);
    rst_state_t state;
    logic [4:0] cnt;
    logic [1:0] por_sync;
    logic [2:0] req, req_q;
    logic [7:0] rstsrc, keep, set_bits;
    logic ext_req, wdt_req;
    rstpin_filter u_filter (
        .clkcpu  (clkcpu),
        .rstn    (rstn),
        .extrst_n(extrst_n),
        .ext_req (ext_req)
    );
`ifdef WDT_RESET_EN
    assign wdt_req = wdtreq;
`else
    assign wdt_req = wdtreq & 1'b0;
`endif
    always_comb begin
        req = {wdt_req, srstreq, ext_req};
        set_bits = '0;
        set_bits[RS_EXT] = ext_req;
        set_bits[RS_SOFT] = srstreq;
        set_bits[RS_WDT] = wdt_req;
        keep = (sfrwe && sfraddr == RSTSRC_ID) ? sfrdatai : 8'hff;
        sfrdatao = (sfraddr == RSTSRC_ID) ? rstsrc : 8'h00;
    end
    // In ST_ASSERT only a newly arriving request extends the reset, so a held request does not stall it.
    always_ff @(posedge clkcpu or negedge rstn) begin
        if (!rstn) begin
            state <= ST_ASSERT;
            resetff <= 1'b1;
            cnt <= '0;
            por_sync <= '0;
            req_q <= '0;
            rstsrc <= RSTSRC_RST;
        end else begin
            por_sync <= {por_sync[0], 1'b1};
            req_q <= req;
            rstsrc <= ((rstsrc & keep) | set_bits) & 8'h0f;
            if (state == ST_RUN) begin
                if (|req) begin
                    state <= ST_ASSERT;
                    resetff <= 1'b1;
                    cnt <= '0;
                end
            end else if (|(req & ~req_q)) begin
                cnt <= '0;
            end else if (por_sync[1]) begin
                if (cnt == LAST) begin
                    state <= ST_RUN;
                    resetff <= 1'b0;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized checks of reset_sequencer against a cycle-level behavioural model
module tb_reset_sequencer;
    localparam int RST = 16;
`ifdef WDT_RESET_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif
    logic clkcpu = 1'b0;
    logic rstn = 1'b1;
    logic extrst_n = 1'b1;
    logic srstreq = 1'b0;
    logic wdtreq = 1'b0;
    logic [6:0] sfraddr = 7'h71;
    logic [7:0] sfrdatai = 8'h00;
    logic sfrwe = 1'b0;
    logic [7:0] sfrdatao;
    logic resetff;
    int tests = 0;
    int fails = 0;
    int hi_total = 0;
    int base;
    bit chk_en = 1'b0;
    int m_left;
    logic m_rf;
    logic [3:0] m_cause;
    logic [2:0] m_prev;
    logic [4:0] m_hist;

    always #5 clkcpu = ~clkcpu;

    reset_sequencer #(.RST_CYCLES(RST), .RSTSRC_ID(7'h71)) dut (
        .clkcpu  (clkcpu),
        .rstn    (rstn),
        .extrst_n(extrst_n),
        .srstreq (srstreq),
        .wdtreq  (wdtreq),
        .sfraddr (sfraddr),
        .sfrdatai(sfrdatai),
        .sfrwe   (sfrwe),
        .sfrdatao(sfrdatao),
        .resetff (resetff)
    );

    // Model: m_left counts edges until resetff must fall; m_hist holds past "pin low" samples, newest in bit 0.
    always @(posedge clkcpu or negedge rstn) begin : model
        logic [2:0] r, arr;
        logic [3:0] c;
        if (!rstn) begin
            m_left <= RST + 2;
            m_rf <= 1'b1;
            m_cause <= 4'h1;
            m_prev <= '0;
            m_hist <= '0;
        end else begin
            r = {WDT & wdtreq, srstreq, &m_hist[4:2]};
            arr = r & ~m_prev;
            c = m_cause;
            if (sfrwe && sfraddr == 7'h71) c = c & sfrdatai[3:0];
            c = c | {r, 1'b0};
            m_cause <= c;
            m_prev <= r;
            m_hist <= {m_hist[3:0], ~extrst_n};
            if (!m_rf) begin
                if (|r) begin
                    m_rf <= 1'b1;
                    m_left <= RST;
                end
            end else if (|arr) begin
                m_left <= (m_left - 1 > RST) ? m_left - 1 : RST;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) m_rf <= 1'b0;
            end
        end
    end

    always @(negedge clkcpu) begin
        if (chk_en) begin
            if (resetff === 1'b1) hi_total++;
            tests++;
            if (resetff !== m_rf) begin
                fails++;
                $display("FAIL cyc_resetff t=%0t got %b expected %b", $time, resetff, m_rf);
            end
            tests++;
            if (sfrdatao !== ((sfraddr == 7'h71) ? {4'h0, m_cause} : 8'h00)) begin
                fails++;
                $display("FAIL cyc_sfrdatao t=%0t got %h expected %h", $time, sfrdatao,
                         (sfraddr == 7'h71) ? {4'h0, m_cause} : 8'h00);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clkcpu);
        #1;
    endtask

    initial begin
        #1 rstn = 1'b0;
        chk_en = 1'b1;
        #1 chk("por_async", 32'(resetff), 32'd1);
        step(5);
        rstn = 1'b1;
        base = hi_total;
        step(30);
        chk("por_len", 32'(hi_total - base), 32'd18);
        chk("por_src", 32'(sfrdatao), 32'h01);

        base = hi_total;
        srstreq = 1'b1;
        step(16);
        srstreq = 1'b0;
        step(20);
        chk("soft_len", 32'(hi_total - base), 32'd16);
        chk("soft_src", 32'(sfrdatao), 32'h05);

        base = hi_total;
        srstreq = 1'b1;
        step();
        srstreq = 1'b0;
        step(10);
        wdtreq = 1'b1;
        step();
        wdtreq = 1'b0;
        step(30);
        chk("ext_len_wdt", 32'(hi_total - base), WDT ? 32'd27 : 32'd16);
        chk("ext_src_wdt", 32'(sfrdatao), WDT ? 32'h0D : 32'h05);

        base = hi_total;
        extrst_n = 1'b0;
        step(2);
        extrst_n = 1'b1;
        step(12);
        chk("pin_short2", 32'(hi_total - base), 32'd0);
        chk("pin_short2_src", 32'(sfrdatao[1]), 32'd0);
        base = hi_total;
        extrst_n = 1'b0;
        step(3);
        extrst_n = 1'b1;
        step(25);
        chk("pin_len3", 32'(hi_total - base), 32'd16);
        base = hi_total;
        extrst_n = 1'b0;
        step(6);
        extrst_n = 1'b1;
        step(30);
        chk("pin_len6", 32'(hi_total - base), 32'd16);
        chk("pin_src", 32'(sfrdatao[1]), 32'd1);

        sfrwe = 1'b1;
        sfrdatai = 8'h00;
        srstreq = 1'b1;
        step();
        sfrwe = 1'b0;
        srstreq = 1'b0;
        step(20);
        chk("race_src", 32'(sfrdatao), 32'h04);
        sfrwe = 1'b1;
        sfrdatai = 8'hff;
        step();
        sfrwe = 1'b0;
        chk("write_ones", 32'(sfrdatao), 32'h04);
        sfraddr = 7'h70;
        sfrwe = 1'b1;
        sfrdatai = 8'h00;
        step();
        sfrwe = 1'b0;
        chk("other_addr_read", 32'(sfrdatao), 32'h00);
        sfraddr = 7'h71;
        #1 chk("other_addr_write", 32'(sfrdatao), 32'h04);

        srstreq = 1'b1;
        step();
        srstreq = 1'b0;
        step(5);
        rstn = 1'b0;
        #1 chk("abort_async", 32'(resetff), 32'd1);
        step(3);
        rstn = 1'b1;
        base = hi_total;
        step(30);
        chk("abort_len", 32'(hi_total - base), 32'd18);
        chk("abort_src", 32'(sfrdatao), 32'h01);

        rstn = 1'b0;
        #1 chk("run_async", 32'(resetff), 32'd1);
        step(2);
        rstn = 1'b1;
        step(25);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(24) == 0) srstreq = ~srstreq;
            if ($urandom_range(39) == 0) wdtreq = ~wdtreq;
            if ($urandom_range(29) == 0) extrst_n = ~extrst_n;
            sfraddr = ($urandom_range(1) == 1) ? 7'h71 : 7'($urandom_range(127));
            sfrwe = ($urandom_range(9) == 0);
            sfrdatai = 8'($urandom);
            if (!rstn) rstn = ($urandom_range(2) == 0);
            else if ($urandom_range(499) == 0) rstn = 1'b0;
            step();
        end
        rstn = 1'b1;
        srstreq = 1'b0;
        wdtreq = 1'b0;
        extrst_n = 1'b1;
        sfrwe = 1'b0;
        step(40);
        chk("final_idle", 32'(resetff), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
